mem_access_unit: RTL

//  Load/store engine feeding stage_mem. Converts one memory request (byte/half/word, load or store) into

---
 rtl/mem_access_unit_pkg.sv | 37 +++
 rtl/mem_load_ext.sv | 29 ++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//   Shared definitions for the load/store engine: register file widths,
//   memory access width codes, FSM state encoding and a helper that maps an
//   access width onto the index of its last byte.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

    // Register file geometry
    localparam int REG_W  = 32;
    localparam int REG_AW = 5;

    // Access width codes carried on width_i
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Engine states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TAIL   = 2'd2,
        ST_DONE   = 2'd3
    } mau_state_t;

    // Index of the final byte of an access; the reserved code behaves as a word
    function automatic logic [1:0] last_index(input logic [1:0] width);
        logic [1:0] idx;
        case (width)
            MEM_BYTE: idx = 2'd0;
            MEM_HALF: idx = 2'd1;
            default:  idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// ---------------------------------------------------------------------------
// mem_load_ext
//   Combinational extension of assembled load data to register width.
//   Ports:
//     data     in  REG_W  little-endian bytes gathered from RAM
//     width    in  2      access width code (byte/half/word, reserved = word)
//     sext     in  1      1 = sign-extend byte/half, 0 = zero-extend
//     ext_data out REG_W  value to write back
// ---------------------------------------------------------------------------
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [REG_W-1:0] data,
    input  logic [1:0]       width,
    input  logic             sext,
    output logic [REG_W-1:0] ext_data
);

    // Replicate the top bit of the loaded field only when sign extension is asked for
    always_comb begin
        ext_data = data;
        case (width)
            MEM_BYTE: ext_data = {{(REG_W-8){sext & data[7]}}, data[7:0]};
            MEM_HALF: ext_data = {{(REG_W-16){sext & data[15]}}, data[15:0]};
            default:  ext_data = data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store engine feeding stage_mem. A byte/half/word request is broken
//   into byte-serial accesses on an 8-bit synchronous RAM port while the
//   pipeline is stalled; non-memory instructions pass straight through.
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     req_i, we_i              memory request, 1 = store
//     width_i, sext_i          access width, load sign-extension
//     addr_i, wdata_i          byte address, store data (low bytes used)
//     write_i, regw_addr_i,
//     regw_data_i              write-back triple from EX/MEM
//     stall_o                  hold upstream stages
//     write_o, regw_addr_o,
//     regw_data_o              write-back triple to stage_mem
//     ram_addr_o, ram_wr_o,
//     ram_dout_o, ram_din_i    byte RAM port (read data one cycle late)
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int RAM_AW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        width_i,
    input  logic              sext_i,
    input  logic [31:0]       addr_i,
    input  logic [REG_W-1:0]  wdata_i,
    input  logic              write_i,
    input  logic [REG_AW-1:0] regw_addr_i,
    input  logic [REG_W-1:0]  regw_data_i,
    output logic              stall_o,
    output logic              write_o,
    output logic [REG_AW-1:0] regw_addr_o,
    output logic [REG_W-1:0]  regw_data_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    mau_state_t        state_q;
    mau_state_t        state_d;
    logic [1:0]        cnt_q;
    logic [1:0]        last_idx;
    logic [1:0]        cap_idx;
    logic              we_q;
    logic [1:0]        width_q;
    logic              sext_q;
    logic [RAM_AW-1:0] base_q;
    logic [REG_W-1:0]  wdata_q;
    logic              write_q;
    logic [REG_AW-1:0] regw_addr_q;
    logic [REG_W-1:0]  data_q;
    logic [REG_W-1:0]  ext_data;

    assign last_idx = last_index(width_q);

    // Read data trails its address by one cycle, so the byte arriving now
    // belongs to the previous counter value
    assign cap_idx = cnt_q - 2'd1;

    mem_load_ext u_load_ext (
        .data     (data_q),
        .width    (width_q),
        .sext     (sext_q),
        .ext_data (ext_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: loads need one extra TAIL cycle for the last byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_i) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == last_idx) state_d = we_q ? ST_DONE : ST_TAIL;
            ST_TAIL:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request capture, byte counter and load data assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 2'd0;
            data_q      <= '0;
            we_q        <= 1'b0;
            width_q     <= MEM_BYTE;
            sext_q      <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            regw_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        cnt_q       <= 2'd0;
                        data_q      <= '0;
                        we_q        <= we_i;
                        width_q     <= width_i;
                        sext_q      <= sext_i;
                        base_q      <= addr_i[RAM_AW-1:0];
                        wdata_q     <= wdata_i;
                        write_q     <= write_i;
                        regw_addr_q <= regw_addr_i;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q && cnt_q != 2'd0) begin
                        data_q[{cap_idx, 3'b000} +: 8] <= ram_din_i;
                    end
                    if (cnt_q == last_idx) begin
                        cnt_q <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_TAIL: begin
                    data_q[{last_idx, 3'b000} +: 8] <= ram_din_i;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: everything is forced low while reset is held; in IDLE without
    // a request the write-back triple is a pure combinational bypass
    always_comb begin
        stall_o     = 1'b0;
        write_o     = 1'b0;
        regw_addr_o = '0;
        regw_data_o = '0;
        ram_addr_o  = '0;
        ram_wr_o    = 1'b0;
        ram_dout_o  = 8'h00;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        stall_o = 1'b1;
                    end else begin
                        write_o     = write_i;
                        regw_addr_o = regw_addr_i;
                        regw_data_o = regw_data_i;
                    end
                end
                ST_ACCESS: begin
                    stall_o    = 1'b1;
                    ram_addr_o = base_q + RAM_AW'(cnt_q);
                    if (we_q) begin
                        ram_wr_o   = 1'b1;
                        ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
                    end
                end
                ST_TAIL: begin
                    stall_o = 1'b1;
                end
                ST_DONE: begin
                    regw_addr_o = regw_addr_q;
                    if (!we_q) begin
                        write_o     = write_q;
                        regw_data_o = ext_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
